fp_sqrt_unrolled: RTL and testbench

- Iterative fixed-point square root. Parametrised successor to the single-bit-per-cycle root unit.
- Adds a configurable number of result bits per clock (UNROLL), an explicit FSM, an async active-low reset, a remainder/exact output and a busy flag.
- Instantiated by the Calyx math primitive library behind the standard go/done interface. An integer-only wrapper sets FRAC_WIDTH=0.

---
 rtl/fp_sqrt_pkg.sv | 20 ++
 rtl/fp_sqrt_step.sv | 29 ++
 rtl/fp_sqrt_unrolled.sv | 153 +++++++++++++++
 tb/tb_fp_sqrt_unrolled.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sqrt_pkg.sv
// Shared types and elaboration helpers for the fixed-point square-root unit.
package fp_sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Root bits produced by a plain truncating root of a WIDTH-bit radicand.
    function automatic int calc_iterations(input int width, input int frac_width);
        return (width + frac_width) / 2;
    endfunction

    // Compute cycles needed to resolve 'steps' root bits, 'unroll' per cycle.
    function automatic int calc_cycles(input int steps, input int unroll);
        return (steps + unroll - 1) / unroll;
    endfunction

endpackage

// File: rtl/fp_sqrt_step.sv
// One restoring square-root sub-step: shift two radicand bits into the partial
// remainder, trial-subtract {q,01}, and append the resulting root bit to q.
module fp_sqrt_step #(
    parameter int Q_W = 16
) (
    input  logic [Q_W+1:0] acc_in,
    input  logic [Q_W-1:0] q_in,
    input  logic [1:0]     bits,
    output logic [Q_W+1:0] acc_out,
    output logic [Q_W-1:0] q_out
);
    localparam int ACC_W = Q_W + 2;

    logic [ACC_W-1:0] acc_sh;
    logic [ACC_W:0]   diff;

    // NOTE: every variable here is assigned on every path, so no latch is inferred.
    always_comb begin
        acc_sh = (acc_in << 2) | ACC_W'(bits);
        diff   = {1'b0, acc_sh} - {1'b0, q_in, 2'b01};
        if (diff[ACC_W]) begin
            acc_out = acc_sh;
        end else begin
            acc_out = diff[ACC_W-1:0];
        end
        q_out = Q_W'({q_in, ~diff[ACC_W]});
    end

endmodule

// File: rtl/fp_sqrt_unrolled.sv
// Iterative fixed-point square root resolving UNROLL root bits per clock.
// Define FP_SQRT_ROUND_EN for a guard iteration and a round-half-up result.
module fp_sqrt_unrolled
    import fp_sqrt_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int UNROLL     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH:0]   rem,
    output logic             exact,
    output logic             busy,
    output logic             done
);
    localparam int ITERATIONS = calc_iterations(WIDTH, FRAC_WIDTH);
`ifdef FP_SQRT_ROUND_EN
    localparam int STEPS = ITERATIONS + 1;
`else
    localparam int STEPS = ITERATIONS;
`endif
    localparam int Q_W   = STEPS;
    localparam int ACC_W = STEPS + 2;
    localparam int X_W   = 2 * STEPS;
    localparam int REM_W = ITERATIONS + 2;
    localparam int CNT_W = $clog2(STEPS + UNROLL + 1);

    if (WIDTH < 2 || FRAC_WIDTH < 0 || FRAC_WIDTH > WIDTH || INT_WIDTH != WIDTH - FRAC_WIDTH
        || ((WIDTH + FRAC_WIDTH) % 2) != 0 || UNROLL < 1 || UNROLL > ITERATIONS) begin : g_param_check
        $error("fp_sqrt_unrolled: illegal parameter combination");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             last_cycle;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_f;
    logic [Q_W-1:0]   q_q;
    logic [Q_W-1:0]   q_f;
    logic [X_W-1:0]   x_q;
    logic [X_W-1:0]   x_f;

    // Sub-steps past STEPS pass their inputs through, covering a partial last cycle.
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [ACC_W-1:0] acc_i;
        logic [ACC_W-1:0] acc_s;
        logic [ACC_W-1:0] acc_o;
        logic [Q_W-1:0]   q_i;
        logic [Q_W-1:0]   q_s;
        logic [Q_W-1:0]   q_o;
        logic [X_W-1:0]   x_i;
        logic [X_W-1:0]   x_o;
        logic             active;

        if (i == 0) begin : g_head
            assign acc_i = acc_q;
            assign q_i   = q_q;
            assign x_i   = x_q;
        end else begin : g_link
            assign acc_i = g_step[i-1].acc_o;
            assign q_i   = g_step[i-1].q_o;
            assign x_i   = g_step[i-1].x_o;
        end

        fp_sqrt_step #(.Q_W(Q_W)) u_step (
            .acc_in (acc_i),
            .q_in   (q_i),
            .bits   (x_i[X_W-1 -: 2]),
            .acc_out(acc_s),
            .q_out  (q_s)
        );

        assign active = cnt < CNT_W'(STEPS - i);
        assign acc_o  = active ? acc_s : acc_i;
        assign q_o    = active ? q_s : q_i;
        assign x_o    = active ? (x_i << 2) : x_i;
    end

    assign acc_f      = g_step[UNROLL-1].acc_o;
    assign q_f        = g_step[UNROLL-1].q_o;
    assign x_f        = g_step[UNROLL-1].x_o;
    assign cnt_next   = cnt + CNT_W'(UNROLL);
    assign last_cycle = cnt_next >= CNT_W'(STEPS);

    logic [Q_W-1:0]   out_calc;
    logic [REM_W-1:0] rem_calc;

`ifdef FP_SQRT_ROUND_EN
    logic [ACC_W:0] rem_sum;

    // The guard step subtracted {t,01} only when q[0]=1; undoing it and dividing
    // by four gives the remainder of the truncated root t = q>>1.
    always_comb begin
        rem_sum  = {1'b0, acc_f} + (q_f[0] ? {2'b00, q_f[Q_W-1:1], 2'b01} : '0);
        rem_calc = REM_W'(rem_sum >> 2);
        out_calc = (q_f >> 1) + Q_W'(q_f[0]);
    end
`else
    assign rem_calc = acc_f;
    assign out_calc = q_f;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            x_q   <= '0;
            out   <= '0;
            rem   <= '0;
            exact <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_COMP;
                        cnt   <= '0;
                        acc_q <= '0;
                        q_q   <= '0;
                        x_q   <= X_W'(in) << (X_W - WIDTH);
                    end
                end
                ST_COMP: begin
                    acc_q <= acc_f;
                    q_q   <= q_f;
                    x_q   <= x_f;
                    cnt   <= cnt_next;
                    if (last_cycle) begin
                        state <= ST_DONE;
                        out   <= WIDTH'(out_calc);
                        rem   <= (WIDTH + 1)'(rem_calc);
                        exact <= (rem_calc == '0);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_COMP);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fp_sqrt_unrolled.sv
// Bench for fp_sqrt_unrolled: three configurations (Q16.16 x1, integer x4, integer x3)
// checked against a binary-search floor-sqrt model through a scoreboard queue.
module tb_fp_sqrt_unrolled;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] out;
        logic [W:0]   rem;
        logic         exact;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic go_a, go_b, go_c;
    logic [W-1:0] in_a, in_b, in_c;
    logic [W-1:0] out_a, out_b, out_c;
    logic [W:0] rem_a, rem_b, rem_c;
    logic exact_a, exact_b, exact_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;

    always #5 clk = ~clk;

    fp_sqrt_unrolled #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .UNROLL(1)) u_dut_a (
        .clk(clk), .reset(reset), .go(go_a), .in(in_a), .out(out_a), .rem(rem_a),
        .exact(exact_a), .busy(busy_a), .done(done_a)
    );
    fp_sqrt_unrolled #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0), .UNROLL(4)) u_dut_b (
        .clk(clk), .reset(reset), .go(go_b), .in(in_b), .out(out_b), .rem(rem_b),
        .exact(exact_b), .busy(busy_b), .done(done_b)
    );
    fp_sqrt_unrolled #(.WIDTH(32), .INT_WIDTH(32), .FRAC_WIDTH(0), .UNROLL(3)) u_dut_c (
        .clk(clk), .reset(reset), .go(go_c), .in(in_c), .out(out_c), .rem(rem_c),
        .exact(exact_c), .busy(busy_c), .done(done_c)
    );

    int cur = 0;
    logic [W-1:0] obs_out;
    logic [W:0]   obs_rem;
    logic         obs_exact, obs_busy, obs_done;

    always_comb begin
        obs_out = out_a; obs_rem = rem_a; obs_exact = exact_a; obs_busy = busy_a; obs_done = done_a;
        if (cur == 1) begin
            obs_out = out_b; obs_rem = rem_b; obs_exact = exact_b; obs_busy = busy_b; obs_done = done_b;
        end else if (cur == 2) begin
            obs_out = out_c; obs_rem = rem_c; obs_exact = exact_c; obs_busy = busy_c; obs_done = done_c;
        end
    end

    exp_t sb[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned lo = 0;
        longint unsigned hi = 64'h8000_0000;
        longint unsigned mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    // Expected results; latency counts edges from the one that samples go up to
    // the edge after which done is seen (N+1).
    function automatic exp_t model(input int sel, input logic [W-1:0] val);
        exp_t e;
        longint unsigned x, t;
        x = 64'(val) << ((sel == 0) ? 16 : 0);
        t = isqrt(x);
        e.rem   = 33'(x - t * t);
        e.exact = (x == t * t);
`ifdef FP_SQRT_ROUND_EN
        begin
            longint unsigned t2;
            t2 = isqrt(x << 2);
            e.out = 32'((t2 >> 1) + (t2 & 64'd1));
        end
        e.lat = (sel == 0) ? 26 : (sel == 1) ? 6 : 7;
`else
        e.out = 32'(t);
        e.lat = (sel == 0) ? 25 : (sel == 1) ? 5 : 7;
`endif
        return e;
    endfunction

    task automatic drive(input int sel, input logic g, input logic [W-1:0] val);
        case (sel)
            0: begin go_a = g; in_a = val; end
            1: begin go_b = g; in_b = val; end
            default: begin go_c = g; in_c = val; end
        endcase
    endtask

    task automatic start_op(input int sel, input logic [W-1:0] val);
        sb.push_back(model(sel, val));
        cur = sel;
        @(negedge clk);
        drive(sel, 1'b1, val);
        @(negedge clk);
        drive(sel, 1'b0, $urandom());
        check("busy_after_go", {63'd0, obs_busy}, 64'd1);
    endtask

    task automatic finish_op(input string tag, input bit toggle);
        int lat = 1;
        exp_t e;
        while (!obs_done && lat < 300) begin
            if (toggle) drive(cur, 1'($urandom_range(0, 1)), $urandom());
            @(negedge clk);
            lat++;
        end
        drive(cur, 1'b0, $urandom());
        check({tag, "_done"}, {63'd0, obs_done}, 64'd1);
        check({tag, "_busy_in_done"}, {63'd0, obs_busy}, 64'd0);
        check({tag, "_sb_nonempty"}, {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_out"}, 64'(obs_out), 64'(e.out));
            check({tag, "_rem"}, 64'(obs_rem), 64'(e.rem));
            check({tag, "_exact"}, {63'd0, obs_exact}, {63'd0, e.exact});
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, obs_done}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no summary by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] hv [4];
        exp_t e;
        int edge_cnt, last_done, n_done, period;

        reset = 1'b0;
        go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 64'(out_a), 64'd0);
        check("rst_rem", 64'(rem_a), 64'd0);
        check("rst_exact", {63'd0, exact_a}, 64'd0);
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_done", {63'd0, done_a}, 64'd0);
        reset = 1'b1;

        // Q16.16, one bit per cycle
        start_op(0, 32'h0004_0000);
        finish_op("a_4p0", 1'b0);
        check("a_4p0_const_out", 64'(out_a), 64'h0002_0000);
        check("a_4p0_const_exact", {63'd0, exact_a}, 64'd1);
        start_op(0, 32'h0002_0000);
        finish_op("a_2p0", 1'b0);
`ifdef FP_SQRT_ROUND_EN
        check("a_2p0_const_out", 64'(out_a), 64'h0001_6A0A);
`else
        check("a_2p0_const_out", 64'(out_a), 64'h0001_6A09);
`endif
        check("a_2p0_const_exact", {63'd0, exact_a}, 64'd0);

        // Integer, four bits per cycle
        start_op(1, 32'hFFFF_FFFF);
        finish_op("b_max", 1'b0);
`ifdef FP_SQRT_ROUND_EN
        check("b_max_const_out", 64'(out_b), 64'd65536);
`else
        check("b_max_const_out", 64'(out_b), 64'd65535);
`endif
        check("b_max_const_rem", 64'(rem_b), 64'd131070);

        // Integer, three bits per cycle with a partial last cycle
        start_op(2, 32'd1_000_000);
        finish_op("c_1e6", 1'b0);
        check("c_1e6_const_out", 64'(out_c), 64'd1000);
        start_op(2, 32'd0);
        check("c_hold_out", 64'(out_c), 64'd1000);
        finish_op("c_zero", 1'b0);
        check("c_zero_const_exact", {63'd0, exact_c}, 64'd1);

        // Reset in the middle of a computation aborts it
        cur = 0;
        @(negedge clk);
        drive(0, 1'b1, 32'h0009_0000);
        @(negedge clk);
        drive(0, 1'b0, '0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy_a}, 64'd0);
        check("abort_out", 64'(out_a), 64'd0);
        check("abort_rem", 64'(rem_a), 64'd0);
        check("abort_done", {63'd0, done_a}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        check("abort_no_done_pulse", 64'(n_done), 64'd0);
        start_op(1, 32'd9);
        finish_op("b_nine", 1'b0);
        check("b_nine_const_out", 64'(out_b), 64'd3);

        // go held high: back-to-back operations separated by one IDLE cycle
`ifdef FP_SQRT_ROUND_EN
        period = 7;
`else
        period = 6;
`endif
        hv[0] = 32'd144; hv[1] = 32'hFFFF_FFFF; hv[2] = 32'd2; hv[3] = 32'd1_000_001;
        cur = 1;
        @(negedge clk);
        drive(1, 1'b1, hv[0]);
        sb.push_back(model(1, hv[0]));
        edge_cnt = 0;
        last_done = 0;
        for (int k = 0; k < 4; k++) begin
            int guard = 0;
            do begin
                @(negedge clk);
                edge_cnt++;
                guard++;
            end while (!obs_done && guard < 100);
            check("hold_done", {63'd0, obs_done}, 64'd1);
            if (k > 0) check("hold_period", 64'(edge_cnt - last_done), 64'(period));
            last_done = edge_cnt;
            check("hold_sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("hold_out", 64'(obs_out), 64'(e.out));
                check("hold_rem", 64'(obs_rem), 64'(e.rem));
            end
            if (k < 3) begin
                drive(1, 1'b1, hv[k+1]);
                sb.push_back(model(1, hv[k+1]));
            end else begin
                drive(1, 1'b0, '0);
            end
        end
        repeat (3) @(negedge clk);

        // Random sweep with go and in toggled while busy
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] v;
            v = (k % 4 == 0) ? W'($urandom_range(0, 1000)) : W'($urandom());
            start_op(k % 3, v);
            finish_op("rand", 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
